fetch_exec_sequencer: RTL

- Sequences the fetch/execute handshake between the instruction fetcher and the executor.
- Waits for a valid command from the fetcher and starts the executor.
- When the executor finishes, retires the command by pulsing READY_FL_ with either the next-address size or the jump offset.
- Also handles halt detection, single-step mode, an executor timeout watchdog and a retired-instruction counter.

---
 rtl/fetch_exec_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_exec_sequencer.sv
// fetch_exec_sequencer
// Coordinates the fetcher and the executor. It accepts a valid command,
// starts the executor, and retires the command back to the fetcher with
// either the command size or a jump offset. It also detects halt, supports
// single-step mode, enforces an executor timeout, and counts retired commands.
module fetch_exec_sequencer #(
    parameter int                      ADDR_SIZE_    = 32,
    parameter int                      OPCODE_SIZE_  = 8,
    parameter logic [OPCODE_SIZE_-1:0] HALT_OPCODE_  = 8'hFF,
    parameter int                      EXEC_TIMEOUT_ = 16,
    parameter int                      CNT_SIZE_     = 32
) (
    input  logic                    CLK_,
    input  logic                    RST_,
    input  logic                    START_,
    input  logic                    STEP_EN_,
    input  logic                    STEP_,
    input  logic                    EXEC_FL_,
    input  logic [OPCODE_SIZE_-1:0] CMD_OPCODE_,
    input  logic [1:0]              CMD_SIZE_,
    output logic                    EXEC_START_,
    input  logic                    EXEC_DONE_,
    input  logic                    BRANCH_TAKEN_,
    input  logic [ADDR_SIZE_-1:0]   BRANCH_OFFSET_,
    output logic                    READY_FL_,
    output logic                    JMP_FL_,
    output logic [ADDR_SIZE_-1:0]   NEW_EXEC_ADDR_OFFSET_,
    output logic [1:0]              PREV_CMD_SIZE_,
    output logic                    BUSY_,
    output logic                    HALTED_,
    output logic                    ERROR_,
    output logic [CNT_SIZE_-1:0]    RETIRED_CNT_
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_RETIRE = 3'd3;
    localparam logic [2:0] S_PAUSE  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    // The timer counts completed EXEC cycles; the last legal value is one
    // below the limit, so the executor gets exactly EXEC_TIMEOUT_ cycles.
    localparam logic [15:0] TIMER_LAST = 16'(EXEC_TIMEOUT_ - 1);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [15:0] exec_timer;
    logic [1:0]  cmd_size_q;
    logic        cmd_halt;
    logic        cmd_bad_size;
    logic        cmd_accept;
    logic        exec_finish;
    logic        exec_timed_out;

    // Decode the current command and executor events for the state machine.
    always_comb begin
        cmd_halt       = 1'b0;
        cmd_bad_size   = 1'b0;
        cmd_accept     = 1'b0;
        exec_finish    = 1'b0;
        exec_timed_out = 1'b0;
        if (state == S_WAIT && EXEC_FL_) begin
            cmd_halt     = (CMD_OPCODE_ == HALT_OPCODE_);
            cmd_bad_size = !cmd_halt && (CMD_SIZE_ == 2'd0);
            cmd_accept   = !cmd_halt && (CMD_SIZE_ != 2'd0);
        end
        if (state == S_EXEC) begin
            exec_finish    = EXEC_DONE_;
            exec_timed_out = !EXEC_DONE_ && (exec_timer == TIMER_LAST);
        end
    end

    // Next-state selection; HALT and ERROR only leave through reset.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (START_) next_state = S_WAIT;
            S_WAIT: begin
                if (cmd_halt)          next_state = S_HALT;
                else if (cmd_bad_size) next_state = S_ERROR;
                else if (cmd_accept)   next_state = S_EXEC;
            end
            S_EXEC: begin
                if (exec_finish)         next_state = S_RETIRE;
                else if (exec_timed_out) next_state = S_ERROR;
            end
            S_RETIRE: next_state = STEP_EN_ ? S_PAUSE : S_WAIT;
            S_PAUSE:  if (STEP_ || !STEP_EN_) next_state = S_WAIT;
            S_HALT:   next_state = S_HALT;
            S_ERROR:  next_state = S_ERROR;
            default:  next_state = S_IDLE;
        endcase
    end

    // State register plus registered status flags and handshake pulses.
    always_ff @(posedge CLK_) begin
        if (RST_) begin
            state       <= S_IDLE;
            EXEC_START_ <= 1'b0;
            READY_FL_   <= 1'b0;
            BUSY_       <= 1'b0;
            HALTED_     <= 1'b0;
            ERROR_      <= 1'b0;
        end else begin
            state       <= next_state;
            EXEC_START_ <= cmd_accept;
            READY_FL_   <= exec_finish;
            BUSY_       <= (next_state == S_WAIT) || (next_state == S_EXEC) ||
                           (next_state == S_RETIRE) || (next_state == S_PAUSE);
            HALTED_     <= (next_state == S_HALT);
            ERROR_      <= (next_state == S_ERROR);
        end
    end

    // Capture the command size at acceptance and run the executor watchdog.
    always_ff @(posedge CLK_) begin
        if (RST_) begin
            cmd_size_q <= 2'd0;
            exec_timer <= 16'd0;
        end else if (cmd_accept) begin
            cmd_size_q <= CMD_SIZE_;
            exec_timer <= 16'd0;
        end else if (state == S_EXEC) begin
            exec_timer <= exec_timer + 16'd1;
        end
    end

    // Latch the executor result and count the retirement when it completes.
    always_ff @(posedge CLK_) begin
        if (RST_) begin
            JMP_FL_               <= 1'b0;
            NEW_EXEC_ADDR_OFFSET_ <= '0;
            PREV_CMD_SIZE_        <= 2'd0;
            RETIRED_CNT_          <= '0;
        end else if (exec_finish) begin
            JMP_FL_               <= BRANCH_TAKEN_;
            NEW_EXEC_ADDR_OFFSET_ <= BRANCH_OFFSET_;
            PREV_CMD_SIZE_        <= cmd_size_q;
            RETIRED_CNT_          <= RETIRED_CNT_ + 1'b1;
        end
    end

endmodule
